// File: rtl/dmem_access_stage_if.sv
// Bus between the pipeline and the data-memory stage: request side driven by
// the pipeline (master), response side driven by dmem_access_stage (slave).
interface dmem_access_stage_if;
   logic        mem_r;
   logic        mem_w;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  write_en;
   logic [31:0] rdata;
   logic        done;
   logic        stall;
   logic        parity_err;

   modport master (
      output mem_r, mem_w, addr, wdata, write_en,
      input  rdata, done, stall, parity_err
   );

   modport slave (
      input  mem_r, mem_w, addr, wdata, write_en,
      output rdata, done, stall, parity_err
   );
endinterface

// File: rtl/dmem_access_stage.sv
// Data-memory stage: word RAM behind an IDLE/BUSY handshake with fixed wait states.
// Define DMEM_BYTE_PARITY_EN to add per-byte even parity checked on every read.
module dmem_access_stage #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   dmem_access_stage_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [2:0]  WS = 3'(WAIT_STATES);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    we_q, we_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          done_q, done_d;
   logic          perr_q, perr_d;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic [31:0]   word;
   logic          req, accept, fire;
   logic [3:0]    par_bad;

   assign idx    = addr_q[AW+1:2];
   assign word   = mem[idx];
   assign req    = bus.mem_r | bus.mem_w;
   // done_q blocks re-accepting the request that just completed
   assign accept = (state_q == IDLE) && req && !done_q;
   assign fire   = (state_q == BUSY) && (cnt_q == '0);

   assign bus.stall      = rst_n & ((state_q == BUSY) | accept);
   assign bus.rdata      = rdata_q;
   assign bus.done       = done_q;
   assign bus.parity_err = perr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      perr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d  = bus.addr[AW+1:0];
               wdata_d = bus.wdata;
               we_d    = bus.write_en;
               rd_d    = bus.mem_r;
               wr_d    = bus.mem_w;
               cnt_d   = WS;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (rd_q) begin
                  // word is sampled before the same-edge write: read-before-write
                  rdata_d = word >> {addr_q[1:0], 3'b000};
                  perr_d  = |par_bad;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= '1;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         perr_q  <= perr_d;
      end
   end

   // RAM is not reset; rst_n gating drops a write whose final edge lands in reset
   always_ff @(posedge clk) begin
      if (rst_n && fire && wr_q) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (!we_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

`ifdef DMEM_BYTE_PARITY_EN
   logic [3:0] par_mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (rst_n && fire && wr_q) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (!we_q[i]) par_mem[idx][i] <= ^wdata_q[8*i +: 8];
         end
      end
   end

   always_comb begin
      par_bad = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         par_bad[i] = (^word[8*i +: 8]) != par_mem[idx][i];
      end
   end
`else
   assign par_bad = '0;
`endif

endmodule

// File: tb/tb_dmem_access_stage.sv
// Scoreboard bench for dmem_access_stage: a word-array model predicts aligned
// read data and the handshake length of every access.
module tb_dmem_access_stage;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned WS    = 1;

   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  we;
   } op_t;

   typedef struct {
      int unsigned stalls;
      bit          done_seen;
      logic        stall_at_done;
      logic [31:0] rdata;
      logic        perr;
      logic        reaccept;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   dmem_access_stage_if bus ();

   dmem_access_stage #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES(WS)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int unsigned tests_run = 0;
   int unsigned tests_failed = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model [int unsigned];
   logic [31:0] last_rd = '0;

   task automatic idle_inputs();
      bus.mem_r    = 1'b0;
      bus.mem_w    = 1'b0;
      bus.addr     = '0;
      bus.wdata    = '0;
      bus.write_en = '1;
   endtask

   // Updates the model, pushes the expected read word, then drives the request until done.
   task automatic do_op(input op_t op, output obs_t o);
      int unsigned w;
      logic [31:0] cur;
      o = '{default: '0};
      w = (op.a >> 2) % DEPTH;
      cur = model.exists(w) ? model[w] : 32'h0;
      if (op.r) exp_q.push_back(cur >> (8 * op.a[1:0]));
      if (op.w) begin
         for (int i = 0; i < 4; i++) if (!op.we[i]) cur[8*i +: 8] = op.d[8*i +: 8];
         model[w] = cur;
      end
      @(negedge clk);
      bus.mem_r = op.r; bus.mem_w = op.w; bus.addr = op.a; bus.wdata = op.d; bus.write_en = op.we;
      #1;
      for (int c = 0; c < 40; c++) begin
         if (bus.done === 1'b1) begin
            o.done_seen = 1'b1;
            o.stall_at_done = bus.stall;
            o.rdata = bus.rdata;
            o.perr = bus.parity_err;
            break;
         end
         if (bus.stall === 1'b1) o.stalls++;
         @(negedge clk); #1;
      end
      @(negedge clk);
      idle_inputs();
      #1;
      o.reaccept = bus.stall | bus.done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      bus.mem_r = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      tests_run++;
      if (bus.rdata !== 32'h0 || bus.done !== 1'b0 || bus.stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: rdata=%h done=%b stall=%b, required rdata=00000000 done=0 stall=0", bus.rdata, bus.done, bus.stall);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (bus.stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release_stall: stall=%b, required 1", bus.stall);
      end
      bus.mem_r = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      tests_run++;
      if (bus.stall !== 1'b0 || bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle: stall=%b done=%b, required 0 0", bus.stall, bus.done);
      end
      last_rd = '0;
   endtask

   task automatic test_store_word();
      op_t ops[2] = '{'{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'h0}, '{1'b1, 1'b0, 32'h10, 32'h0, 4'hF}};
      obs_t o;
      logic [31:0] exp;
      foreach (ops[k]) begin
         do_op(ops[k], o);
         exp = ops[k].r ? exp_q.pop_front() : last_rd;
         tests_run += 3;
         if (!o.done_seen || o.stalls != WS + 2 || o.stall_at_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_word_handshake op%0d: stalls=%0d done=%0b stall_at_done=%b, required stalls=%0d done=1 stall_at_done=0", k, o.stalls, o.done_seen, o.stall_at_done, WS + 2);
         end
         if (o.rdata !== exp || o.perr !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_word_data op%0d: rdata=%h perr=%b, required rdata=%h perr=0", k, o.rdata, o.perr, exp);
         end
         if (o.reaccept !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_word_reaccept op%0d: stall/done after done=%b, required 0", k, o.reaccept);
         end
         last_rd = exp;
      end
   endtask

   task automatic test_store_byte();
      op_t ops[4] = '{'{1'b0, 1'b1, 32'h13, 32'hA5000000, 4'h7}, '{1'b1, 1'b0, 32'h13, 32'h0, 4'hF},
                      '{1'b1, 1'b0, 32'h12, 32'h0, 4'hF}, '{1'b1, 1'b0, 32'h10, 32'h0, 4'hF}};
      obs_t o;
      logic [31:0] exp;
      foreach (ops[k]) begin
         do_op(ops[k], o);
         exp = ops[k].r ? exp_q.pop_front() : last_rd;
         tests_run += 2;
         if (!o.done_seen || o.stalls != WS + 2 || o.reaccept !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_byte_handshake op%0d: stalls=%0d done=%0b reaccept=%b, required stalls=%0d done=1 reaccept=0", k, o.stalls, o.done_seen, o.reaccept, WS + 2);
         end
         if (o.rdata !== exp || o.perr !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_byte_data op%0d: rdata=%h perr=%b, required rdata=%h perr=0", k, o.rdata, o.perr, exp);
         end
         last_rd = exp;
      end
   endtask

   task automatic test_read_before_write();
      op_t ops[3] = '{'{1'b0, 1'b1, 32'h20, 32'h11111111, 4'h0}, '{1'b1, 1'b1, 32'h20, 32'h22222222, 4'h0},
                      '{1'b1, 1'b0, 32'h20, 32'h0, 4'hF}};
      obs_t o;
      logic [31:0] exp;
      foreach (ops[k]) begin
         do_op(ops[k], o);
         exp = ops[k].r ? exp_q.pop_front() : last_rd;
         tests_run += 2;
         if (!o.done_seen || o.stalls != WS + 2 || o.reaccept !== 1'b0) begin
            tests_failed++;
            $display("FAIL rbw_handshake op%0d: stalls=%0d done=%0b reaccept=%b, required stalls=%0d done=1 reaccept=0", k, o.stalls, o.done_seen, o.reaccept, WS + 2);
         end
         if (o.rdata !== exp || o.perr !== 1'b0) begin
            tests_failed++;
            $display("FAIL rbw_data op%0d: rdata=%h perr=%b, required rdata=%h perr=0", k, o.rdata, o.perr, exp);
         end
         last_rd = exp;
      end
   endtask

   task automatic test_reset_mid_access();
      op_t init = '{1'b0, 1'b1, 32'h30, 32'h0, 4'h0};
      op_t rd   = '{1'b1, 1'b0, 32'h30, 32'h0, 4'hF};
      obs_t o;
      logic [31:0] exp;
      bit done_seen;
      do_op(init, o);
      tests_run++;
      if (!o.done_seen) begin
         tests_failed++;
         $display("FAIL reset_mid_init: done=%0b, required 1", o.done_seen);
      end
      @(negedge clk);
      bus.mem_w = 1'b1; bus.addr = 32'h30; bus.wdata = 32'hCAFEF00D; bus.write_en = 4'h0;
      @(negedge clk);
      #1;
      tests_run++;
      if (bus.stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_mid_busy: stall=%b, required 1", bus.stall);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.stall !== 1'b0 || bus.done !== 1'b0 || bus.rdata !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_mid_state: stall=%b done=%b rdata=%h, required 0 0 00000000", bus.stall, bus.done, bus.rdata);
      end
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      last_rd = '0;
      done_seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); #1;
         if (bus.done === 1'b1) done_seen = 1'b1;
      end
      tests_run++;
      if (done_seen) begin
         tests_failed++;
         $display("FAIL reset_mid_no_done: done pulse seen=1, required 0");
      end
      do_op(rd, o);
      exp = exp_q.pop_front();
      tests_run++;
      if (!o.done_seen || o.rdata !== exp) begin
         tests_failed++;
         $display("FAIL reset_mid_readback: done=%0b rdata=%h, required done=1 rdata=%h", o.done_seen, o.rdata, exp);
      end
      last_rd = exp;
   endtask

   task automatic test_wrap_noop();
      op_t ops[4] = '{'{1'b0, 1'b1, 32'h1000, 32'h12345678, 4'h0}, '{1'b1, 1'b0, 32'h0, 32'h0, 4'hF},
                      '{1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'hF}, '{1'b1, 1'b0, 32'h0, 32'h0, 4'hF}};
      obs_t o;
      logic [31:0] exp;
      foreach (ops[k]) begin
         do_op(ops[k], o);
         exp = ops[k].r ? exp_q.pop_front() : last_rd;
         tests_run += 2;
         if (!o.done_seen || o.stalls != WS + 2 || o.reaccept !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_handshake op%0d: stalls=%0d done=%0b reaccept=%b, required stalls=%0d done=1 reaccept=0", k, o.stalls, o.done_seen, o.reaccept, WS + 2);
         end
         if (o.rdata !== exp || o.perr !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_data op%0d: rdata=%h perr=%b, required rdata=%h perr=0", k, o.rdata, o.perr, exp);
         end
         last_rd = exp;
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_store_word();
      test_store_byte();
      test_read_before_write();
      test_reset_mid_access();
      test_wrap_noop();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dmem_access_stage.md
Name: dmem_access_stage

Overview:
Data-memory stage between the store-formatting stage and the load-extension stage of the core.
- Takes a lane-positioned store word with active-low byte-lane write enables, or a load request.
- Accesses an internal word-organised RAM after a fixed number of wait states.
- Returns the read word right-aligned to the byte address, so the load stage only sign/zero-extends from bit 7 or bit 15.
- Stalls the pipeline through a stall/done handshake.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM (power of two)
WAIT_STATES, 1, extra busy cycles per access (0..7)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
mem_r  input  1  load request
mem_w  input  1  store request
addr  input  32  byte address
wdata  input  32  store data, already placed in its byte lanes
write_en  input  4  per-byte write enables, active-low (bit i = byte i); 1111 = no byte written
rdata  output  32  read word shifted right by 8*addr[1:0], zero-filled at top
done  output  1  one-cycle pulse: access completed
stall  output  1  hold pipeline (combinational)
parity_err  output  1  parity mismatch on completed read (see Optional Feature)

Behaviour:
- Reset values: state IDLE, wait counter 0, rdata 0, done 0, parity_err 0.
- stall = 0 immediately after reset.
- RAM contents are not reset.
- FSM states: IDLE and BUSY.
- Accept condition: state IDLE, (mem_r | mem_w) = 1 and done = 0.
  - At the accepting edge, capture addr, wdata, write_en, mem_r and mem_w.
  - Load the counter with WAIT_STATES and go to BUSY.
- BUSY, counter non-zero: decrement the counter.
- BUSY, counter zero: perform the access at that edge, then go to IDLE with done = 1 for exactly one cycle.
  - Write: for each i with write_en[i] = 0, write byte i of wdata to byte i of word addr[log2(DEPTH_WORDS)+1:2].
  - Read: rdata <= RAM word >> (8*addr[1:0]).
- stall = (state == BUSY) | (state == IDLE & (mem_r | mem_w) & !done).
- Timing per access: stall is high for exactly WAIT_STATES+2 cycles; done is high in the next cycle, with stall low.
- In the done cycle the pipeline advances. The request still present on the inputs is the completed one and is not re-accepted, so back-to-back accesses always have a one-cycle gap.
- mem_r and mem_w both set: treat as read-before-write. rdata returns the pre-write word, aligned; the write is applied at the same edge.
- mem_w with write_en = 1111: no byte changes; full handshake still occurs.
- rdata updates only on completed reads; it holds its value across writes and idle cycles.
- Address bits above the RAM index are ignored, so addresses wrap modulo DEPTH_WORDS*4. No misalignment checking.
- Reset asserted during BUSY: return to IDLE immediately. The pending write is discarded, RAM is unchanged and done does not pulse.
- Input changes during BUSY are ignored; captured values are used.

Optional Feature:
Macro: DMEM_BYTE_PARITY_EN.
- Defined:
  - Store one even-parity bit per byte alongside the RAM; update it with every byte write.
  - On a completed read, recompute parity on all four bytes.
  - parity_err pulses together with done if any lane mismatches.
  - A byte never written since power-up may flag; the bench initialises memory first.
- Undefined: no parity storage; parity_err tied to 0.

Test Plan:
- Reset: hold rst_n = 0 with mem_r = 1 -> rdata = 0x00000000, done = 0, stall = 0; release -> stall = 1.
- Store word, WAIT_STATES = 1: mem_w, addr 0x10, wdata 0xDEADBEEF, write_en 0000, held until done -> stall high 3 cycles, done 1 cycle, request not re-accepted. Then load from 0x10 -> rdata 0xDEADBEEF.
- Store byte over the previous word: addr 0x13, wdata 0xA5000000, write_en 0111. Then load 0x13 -> rdata 0x000000A5; load 0x12 -> rdata 0x0000A5AD; load 0x10 -> 0xA5ADBEEF.
- Read-before-write: word 0x20 holds 0x11111111; mem_r = mem_w = 1, wdata 0x22222222, write_en 0000 -> rdata 0x11111111; next load of 0x20 -> 0x22222222.
- Reset mid-access: store 0xCAFEF00D to 0x30 (word holds 0x0), pulse rst_n low in a BUSY cycle -> no done pulse; later load of 0x30 -> 0x00000000.
- Wrap and no-op write: DEPTH_WORDS = 1024, store 0x12345678 to 0x1000 -> load of 0x0 returns 0x12345678. A mem_w with write_en 1111 -> done pulses, contents unchanged, parity_err = 0.
